orion_bus_fabric: RTL and testbench
===================================

// Module: orion_bus_fabric
// PURPOSE
//  Parametrised N-requester x M-target memory interconnect, successor to the fixed 2:1 arbiter + single-SPRAM SoC path.
//  Round-robin arbitrates NMASTERS core-side ports, decodes the address against NTARGETS base/size regions, forwards
//  the offset address to the hit target, and returns decode-miss and timeout errors. One transaction outstanding at a time.
// PARAMETERS
//  NMASTERS    2                 number of requester ports (>=1)
//  NTARGETS    2                 number of target regions (>=1)
//  ADDRW       32                address width
//  DATAW       32                data width
//  MASKW       DATAW/8           byte-mask width
//  TGT_BASE    {NTARGETS*ADDRW}  packed region bases, target t in [t*ADDRW +: ADDRW]
//  TGT_SIZE    {NTARGETS*ADDRW}  packed region sizes in bytes, same packing
//  TIMEOUT     255               max cycles a target may take to respond; 0 disables timeout
// PORTS
//  clk_i        in   1               clock
//  rst_i        in   1               synchronous active-high reset
//  m_addr_i     in   NMASTERS*ADDRW  requester address, port p in [p*W +: W] (all packed buses likewise)
//  m_wdata_i    in   NMASTERS*DATAW  requester write data
//  m_mask_i     in   NMASTERS*MASKW  requester byte mask
//  m_we_i       in   NMASTERS        write enable
//  m_valid_i    in   NMASTERS        request valid, held until m_resp_o
//  m_rdata_o    out  NMASTERS*DATAW  read data, valid with m_resp_o
//  m_resp_o     out  NMASTERS        one-cycle completion pulse
//  m_err_o      out  NMASTERS        error flag, qualified by m_resp_o
//  t_addr_o     out  NTARGETS*ADDRW  target-relative address (addr - TGT_BASE[t])
//  t_wdata_o    out  NTARGETS*DATAW  write data;  t_mask_o out NTARGETS*MASKW byte mask
//  t_we_o       out  NTARGETS        write enable
//  t_valid_o    out  NTARGETS        target request, held until t_resp_i
//  t_rdata_i    in   NTARGETS*DATAW  target read data, valid with t_resp_i
//  t_resp_i     in   NTARGETS        target completion pulse
//  err_addr_o   out  ADDRW           address of most recent errored transaction
//  err_count_o  out  16              errored-transaction count, saturates at 16'hFFFF
// BEHAVIOUR
//  - FSM IDLE -> REQ -> RESP -> IDLE; decode miss IDLE -> RESP. All outputs registered.
//  - IDLE: scan m_valid_i from rr_ptr upward (wrap); first hit = grant g. Latch addr/wdata/mask/we/g, decode.
//  - Decode: hit iff TGT_BASE[t] <= addr < TGT_BASE[t]+TGT_SIZE[t], computed in ADDRW+1 bits (no wrap); lowest t wins.
//  - REQ: t_valid_o[t]=1 with latched fields; other targets' valid 0, their t_* buses 0. Timer counts REQ cycles.
//  - t_resp_i[t] in REQ -> RESP next cycle: m_resp_o[g]=1, m_rdata_o[g]=t_rdata_i[t], m_err_o[g]=0; t_valid_o drops.
//  - Miss -> RESP next cycle with m_err_o[g]=1, rdata 0; no target strobed.
//  - TIMEOUT!=0, timer==TIMEOUT with no t_resp_i -> drop t_valid_o, RESP with m_err_o[g]=1, rdata 0.
//  - Error: err_addr_o<=latched addr, err_count_o+1 (saturating), updated in the RESP cycle.
//  - RESP lasts exactly 1 cycle; m_valid_i ignored in it; rr_ptr<=(g+1)%NMASTERS; then IDLE.
//  - Zero-wait target: m_valid at cycle 0 -> t_valid cycle 1, t_resp cycle 1 -> m_resp cycle 2; re-grant cycle 3.
//  - Non-granted m_rdata_o slices, m_resp_o, m_err_o are 0. t_resp_i outside REQ or from non-selected target: ignored.
//  - Reset (any state): next cycle all outputs 0, state IDLE, rr_ptr 0, timer 0, err_count_o 0, err_addr_o 0.
// TESTING
//  1. TGT_BASE={0x8000_0000,0x0}, sizes 0x1000; M0 read 0x8000_0010, T1 0-wait rdata 0xDEADBEEF
//     -> t_addr_o[1]=0x10, m_resp_o[0] cycle 2, rdata 0xDEADBEEF, err 0.
//  2. M0,M1 valid together, rr_ptr 0, held continuously -> grants M0,M1,M0,M1; no double completion per request.
//  3. M1 read 0x0000_5000 (unmapped) -> no t_valid_o, m_resp_o[1]+m_err_o[1] cycle 1, rdata 0,
//     err_addr_o 0x5000, err_count_o 1.
//  4. TIMEOUT=8, T0 never responds -> t_valid_o[0] high 8 cycles, then m_err_o=1; later stray t_resp_i[0] ignored.
//  5. M0 write 0x0000_0004, wdata 0x1234_5678, mask 4'b0011 -> t_we_o[0]=1, t_addr_o[0]=0x4, data/mask unchanged.
//  6. rst_i asserted in REQ -> next cycle all outputs 0; late t_resp_i ignored; next request completes normally.

Source files
------------

// File: rtl/orion_bus_fabric.sv
// N-requester x M-target interconnect: round-robin arbitration, base/size region decode,
// one transaction outstanding, decode-miss and timeout errors reported back to the requester.
module orion_bus_fabric #(
  parameter int          NMASTERS = 2,
  parameter int          NTARGETS = 2,
  parameter int          ADDRW    = 32,
  parameter int          DATAW    = 32,
  parameter int          MASKW    = DATAW / 8,
  parameter logic [NTARGETS*ADDRW-1:0] TGT_BASE = {32'h8000_0000, 32'h0000_0000},
  parameter logic [NTARGETS*ADDRW-1:0] TGT_SIZE = {32'h0000_1000, 32'h0000_1000},
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NMASTERS*ADDRW-1:0] m_addr_i,
  input  logic [NMASTERS*DATAW-1:0] m_wdata_i,
  input  logic [NMASTERS*MASKW-1:0] m_mask_i,
  input  logic [NMASTERS-1:0]       m_we_i,
  input  logic [NMASTERS-1:0]       m_valid_i,
  output logic [NMASTERS*DATAW-1:0] m_rdata_o,
  output logic [NMASTERS-1:0]       m_resp_o,
  output logic [NMASTERS-1:0]       m_err_o,
  output logic [NTARGETS*ADDRW-1:0] t_addr_o,
  output logic [NTARGETS*DATAW-1:0] t_wdata_o,
  output logic [NTARGETS*MASKW-1:0] t_mask_o,
  output logic [NTARGETS-1:0]       t_we_o,
  output logic [NTARGETS-1:0]       t_valid_o,
  input  logic [NTARGETS*DATAW-1:0] t_rdata_i,
  input  logic [NTARGETS-1:0]       t_resp_i,
  output logic [ADDRW-1:0]          err_addr_o,
  output logic [15:0]               err_count_o
);

  // state  | meaning
  // S_IDLE | arbitrate requesters, decode granted address
  // S_REQ  | target strobed, waiting for t_resp_i or timer terminal count
  // S_RESP | one-cycle completion pulse to the granted requester
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  localparam int MW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
  localparam int TW = (NTARGETS > 1) ? $clog2(NTARGETS) : 1;

  state_t          state_q, state_d;
  logic [MW-1:0]   rr_ptr_q;
  logic [MW-1:0]   gnt_q, gnt_c;
  logic [TW-1:0]   tgt_q, tgt_c;
  logic [ADDRW-1:0] addr_q, gnt_addr;
  logic [31:0]     timer_q;
  logic            found_c, hit_c, tresp_c, timeout_c;
  logic [ADDRW:0]  base_x, lim_x, addr_x;
  int              idx;

  always_comb begin
    found_c  = 1'b0;
    gnt_c    = '0;
    hit_c    = 1'b0;
    tgt_c    = '0;
    idx      = 0;
    base_x   = '0;
    lim_x    = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      idx = (int'(rr_ptr_q) + i) % NMASTERS;
      if (!found_c && m_valid_i[idx]) begin
        found_c = 1'b1;
        gnt_c   = MW'(idx);
      end
    end
    gnt_addr = m_addr_i[gnt_c*ADDRW +: ADDRW];
    addr_x   = {1'b0, gnt_addr};
    // Region limit is formed one bit wider so a region ending at the top of the map cannot wrap.
    for (int t = 0; t < NTARGETS; t++) begin
      base_x = {1'b0, TGT_BASE[t*ADDRW +: ADDRW]};
      lim_x  = base_x + {1'b0, TGT_SIZE[t*ADDRW +: ADDRW]};
      if (!hit_c && addr_x >= base_x && addr_x < lim_x) begin
        hit_c = 1'b1;
        tgt_c = TW'(t);
      end
    end
    tresp_c   = t_resp_i[tgt_q];
    timeout_c = (TIMEOUT != 0) && (timer_q == 32'd0);

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found_c) state_d = hit_c ? S_REQ : S_RESP;
      S_REQ:   if (tresp_c || timeout_c) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      tgt_q       <= '0;
      addr_q      <= '0;
      timer_q     <= '0;
      m_rdata_o   <= '0;
      m_resp_o    <= '0;
      m_err_o     <= '0;
      t_addr_o    <= '0;
      t_wdata_o   <= '0;
      t_mask_o    <= '0;
      t_we_o      <= '0;
      t_valid_o   <= '0;
      err_addr_o  <= '0;
      err_count_o <= '0;
    end else begin
      state_q   <= state_d;
      m_resp_o  <= '0;
      m_err_o   <= '0;
      m_rdata_o <= '0;
      case (state_q)
        S_IDLE: begin
          if (found_c) begin
            gnt_q   <= gnt_c;
            tgt_q   <= tgt_c;
            addr_q  <= gnt_addr;
            timer_q <= 32'(TIMEOUT - 1);
            if (hit_c) begin
              t_valid_o[tgt_c]                <= 1'b1;
              t_we_o[tgt_c]                   <= m_we_i[gnt_c];
              t_addr_o[tgt_c*ADDRW +: ADDRW]  <= gnt_addr - TGT_BASE[tgt_c*ADDRW +: ADDRW];
              t_wdata_o[tgt_c*DATAW +: DATAW] <= m_wdata_i[gnt_c*DATAW +: DATAW];
              t_mask_o[tgt_c*MASKW +: MASKW]  <= m_mask_i[gnt_c*MASKW +: MASKW];
            end else begin
              m_resp_o[gnt_c] <= 1'b1;
              m_err_o[gnt_c]  <= 1'b1;
              err_addr_o      <= gnt_addr;
              if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
            end
          end
        end
        S_REQ: begin
          if (tresp_c || timeout_c) begin
            t_valid_o       <= '0;
            t_we_o          <= '0;
            t_addr_o        <= '0;
            t_wdata_o       <= '0;
            t_mask_o        <= '0;
            m_resp_o[gnt_q] <= 1'b1;
            if (tresp_c) begin
              m_rdata_o[gnt_q*DATAW +: DATAW] <= t_rdata_i[tgt_q*DATAW +: DATAW];
            end else begin
              m_err_o[gnt_q] <= 1'b1;
              err_addr_o     <= addr_q;
              if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
            end
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        S_RESP: rr_ptr_q <= MW'((int'(gnt_q) + 1) % NMASTERS);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_orion_bus_fabric.sv
// Directed bench for orion_bus_fabric: 2 requesters, 2 targets (T0 at 0x0, T1 at 0x8000_0000), TIMEOUT 8.
module tb_orion_bus_fabric;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] m_addr = '0, m_wdata = '0;
  logic [7:0]  m_mask = '0;
  logic [1:0]  m_we = '0, m_valid = '0;
  logic [63:0] m_rdata;
  logic [1:0]  m_resp, m_err;
  logic [63:0] t_addr, t_wdata;
  logic [7:0]  t_mask;
  logic [1:0]  t_we, t_valid;
  logic [63:0] t_rdata = '0;
  logic [1:0]  t_resp = '0;
  logic [31:0] err_addr;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  orion_bus_fabric #(
    .NMASTERS(2), .NTARGETS(2), .ADDRW(32), .DATAW(32), .MASKW(4),
    .TGT_BASE({32'h8000_0000, 32'h0000_0000}),
    .TGT_SIZE({32'h0000_1000, 32'h0000_1000}),
    .TIMEOUT(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_mask_i(m_mask), .m_we_i(m_we), .m_valid_i(m_valid),
    .m_rdata_o(m_rdata), .m_resp_o(m_resp), .m_err_o(m_err),
    .t_addr_o(t_addr), .t_wdata_o(t_wdata), .t_mask_o(t_mask), .t_we_o(t_we), .t_valid_o(t_valid),
    .t_rdata_i(t_rdata), .t_resp_i(t_resp),
    .err_addr_o(err_addr), .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (m_resp !== 2'b00) begin errors++; $display("FAIL reset_m_resp: got %b expected 00", m_resp); end
    checks++; if (t_valid !== 2'b00) begin errors++; $display("FAIL reset_t_valid: got %b expected 00", t_valid); end
    checks++; if (m_rdata !== 64'h0) begin errors++; $display("FAIL reset_m_rdata: got %h expected 0", m_rdata); end
    checks++; if (t_addr !== 64'h0) begin errors++; $display("FAIL reset_t_addr: got %h expected 0", t_addr); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err_count: got %h expected 0", err_count); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL reset_err_addr: got %h expected 0", err_addr); end
  endtask

  task automatic test_read_zero_wait();
    m_addr[31:0] = 32'h8000_0010;
    m_we         = 2'b00;
    m_valid      = 2'b01;
    step();
    checks++; if (t_valid !== 2'b10) begin errors++; $display("FAIL rd_t_valid: got %b expected 10", t_valid); end
    checks++; if (t_addr[63:32] !== 32'h10) begin errors++; $display("FAIL rd_t_addr1: got %h expected 00000010", t_addr[63:32]); end
    checks++; if (t_addr[31:0] !== 32'h0) begin errors++; $display("FAIL rd_t_addr0: got %h expected 0", t_addr[31:0]); end
    checks++; if (m_resp !== 2'b00) begin errors++; $display("FAIL rd_early_resp: got %b expected 00", m_resp); end
    t_resp          = 2'b10;
    t_rdata[63:32]  = 32'hDEAD_BEEF;
    step();
    t_resp  = 2'b00;
    t_rdata = '0;
    m_valid = 2'b00;
    checks++; if (m_resp !== 2'b01) begin errors++; $display("FAIL rd_m_resp: got %b expected 01", m_resp); end
    checks++; if (m_rdata !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("FAIL rd_m_rdata: got %h expected 00000000deadbeef", m_rdata); end
    checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL rd_m_err: got %b expected 00", m_err); end
    checks++; if (t_valid !== 2'b00) begin errors++; $display("FAIL rd_t_valid_drop: got %b expected 00", t_valid); end
    step();
    checks++; if (m_resp !== 2'b00) begin errors++; $display("FAIL rd_resp_one_cycle: got %b expected 00", m_resp); end
  endtask

  task automatic test_write();
    m_addr[31:0]  = 32'h0000_0004;
    m_wdata[31:0] = 32'h1234_5678;
    m_mask[3:0]   = 4'b0011;
    m_we          = 2'b01;
    m_valid       = 2'b01;
    step();
    checks++; if (t_valid !== 2'b01) begin errors++; $display("FAIL wr_t_valid: got %b expected 01", t_valid); end
    checks++; if (t_we !== 2'b01) begin errors++; $display("FAIL wr_t_we: got %b expected 01", t_we); end
    checks++; if (t_addr[31:0] !== 32'h4) begin errors++; $display("FAIL wr_t_addr: got %h expected 00000004", t_addr[31:0]); end
    checks++; if (t_wdata[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL wr_t_wdata: got %h expected 12345678", t_wdata[31:0]); end
    checks++; if (t_mask[3:0] !== 4'b0011) begin errors++; $display("FAIL wr_t_mask: got %b expected 0011", t_mask[3:0]); end
    checks++; if (t_wdata[63:32] !== 32'h0) begin errors++; $display("FAIL wr_t1_quiet: got %h expected 0", t_wdata[63:32]); end
    t_resp = 2'b01;
    step();
    t_resp  = 2'b00;
    m_valid = 2'b00;
    m_we    = 2'b00;
    checks++; if (m_resp !== 2'b01 || m_err !== 2'b00) begin errors++; $display("FAIL wr_resp: got resp %b err %b expected resp 01 err 00", m_resp, m_err); end
    step();
  endtask

  task automatic test_miss();
    m_addr[63:32] = 32'h0000_5000;
    m_valid       = 2'b10;
    step();
    m_valid = 2'b00;
    checks++; if (m_resp !== 2'b10) begin errors++; $display("FAIL miss_resp: got %b expected 10", m_resp); end
    checks++; if (m_err !== 2'b10) begin errors++; $display("FAIL miss_err: got %b expected 10", m_err); end
    checks++; if (t_valid !== 2'b00) begin errors++; $display("FAIL miss_t_valid: got %b expected 00", t_valid); end
    checks++; if (m_rdata !== 64'h0) begin errors++; $display("FAIL miss_rdata: got %h expected 0", m_rdata); end
    checks++; if (err_addr !== 32'h5000) begin errors++; $display("FAIL miss_err_addr: got %h expected 00005000", err_addr); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL miss_err_count: got %0d expected 1", err_count); end
    step();
    checks++; if (m_resp !== 2'b00) begin errors++; $display("FAIL miss_resp_one_cycle: got %b expected 00", m_resp); end
  endtask

  task automatic test_round_robin();
    int          resp_pulses;
    logic [1:0]  exp_onehot;
    logic [31:0] rd;
    resp_pulses   = 0;
    m_addr[31:0]  = 32'h0000_0008;
    m_addr[63:32] = 32'h8000_0020;
    m_valid       = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_onehot = (k % 2 == 0) ? 2'b01 : 2'b10;
      rd         = 32'hA000_0000 + 32'(k);
      step();
      checks++; if (t_valid !== exp_onehot) begin errors++; $display("FAIL rr_grant%0d: got t_valid %b expected %b", k, t_valid, exp_onehot); end
      if (m_resp !== 2'b00) resp_pulses++;
      t_resp = exp_onehot;
      if (k % 2 == 0) t_rdata[31:0] = rd; else t_rdata[63:32] = rd;
      step();
      t_resp  = 2'b00;
      t_rdata = '0;
      if (m_resp !== 2'b00) resp_pulses++;
      checks++; if (m_resp !== exp_onehot) begin errors++; $display("FAIL rr_resp%0d: got %b expected %b", k, m_resp, exp_onehot); end
      checks++;
      if ((k % 2 == 0 && m_rdata !== {32'h0, rd}) || (k % 2 == 1 && m_rdata !== {rd, 32'h0})) begin
        errors++; $display("FAIL rr_rdata%0d: got %h expected word %h on port %0d", k, m_rdata, rd, k % 2);
      end
      step();
      if (m_resp !== 2'b00) resp_pulses++;
    end
    m_valid = 2'b00;
    step();
    if (m_resp !== 2'b00) resp_pulses++;
    checks++; if (resp_pulses !== 4) begin errors++; $display("FAIL rr_completions: got %0d expected 4", resp_pulses); end
    checks++; if (t_valid !== 2'b00) begin errors++; $display("FAIL rr_idle_after: got t_valid %b expected 00", t_valid); end
  endtask

  task automatic test_timeout();
    m_addr[31:0] = 32'h0000_0100;
    m_valid      = 2'b01;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++; if (t_valid !== 2'b01 || m_resp !== 2'b00) begin errors++; $display("FAIL to_wait%0d: got t_valid %b m_resp %b expected 01 00", i, t_valid, m_resp); end
      step();
    end
    checks++; if (t_valid !== 2'b00) begin errors++; $display("FAIL to_t_valid_drop: got %b expected 00", t_valid); end
    checks++; if (m_resp !== 2'b01 || m_err !== 2'b01) begin errors++; $display("FAIL to_resp_err: got resp %b err %b expected 01 01", m_resp, m_err); end
    checks++; if (m_rdata !== 64'h0) begin errors++; $display("FAIL to_rdata: got %h expected 0", m_rdata); end
    checks++; if (err_addr !== 32'h100) begin errors++; $display("FAIL to_err_addr: got %h expected 00000100", err_addr); end
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL to_err_count: got %0d expected 2", err_count); end
    m_valid        = 2'b00;
    t_resp         = 2'b01;
    t_rdata[31:0]  = 32'hBAD0_BAD0;
    step();
    step();
    t_resp  = 2'b00;
    t_rdata = '0;
    checks++; if (m_resp !== 2'b00 || t_valid !== 2'b00) begin errors++; $display("FAIL to_stray_resp: got m_resp %b t_valid %b expected 00 00", m_resp, t_valid); end
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL to_stray_count: got %0d expected 2", err_count); end
  endtask

  task automatic test_reset_in_req();
    m_addr[31:0] = 32'h8000_0040;
    m_valid      = 2'b01;
    step();
    checks++; if (t_valid !== 2'b10) begin errors++; $display("FAIL rq_t_valid: got %b expected 10", t_valid); end
    rst     = 1'b1;
    m_valid = 2'b00;
    step();
    rst = 1'b0;
    checks++; if (t_valid !== 2'b00 || t_addr !== 64'h0) begin errors++; $display("FAIL rq_reset_t: got t_valid %b t_addr %h expected 00 0", t_valid, t_addr); end
    checks++; if (m_resp !== 2'b00 || err_count !== 16'h0 || err_addr !== 32'h0) begin
      errors++; $display("FAIL rq_reset_m: got resp %b count %h addr %h expected 00 0 0", m_resp, err_count, err_addr);
    end
    t_resp         = 2'b10;
    t_rdata[63:32] = 32'h7777_7777;
    step();
    t_resp  = 2'b00;
    t_rdata = '0;
    checks++; if (m_resp !== 2'b00) begin errors++; $display("FAIL rq_late_resp: got %b expected 00", m_resp); end
    m_valid = 2'b01;
    step();
    checks++; if (t_valid !== 2'b10 || t_addr[63:32] !== 32'h40) begin errors++; $display("FAIL rq_retry_req: got t_valid %b addr %h expected 10 00000040", t_valid, t_addr[63:32]); end
    t_resp         = 2'b10;
    t_rdata[63:32] = 32'h5555_AAAA;
    step();
    t_resp  = 2'b00;
    t_rdata = '0;
    m_valid = 2'b00;
    checks++; if (m_resp !== 2'b01 || m_rdata !== 64'h0000_0000_5555_AAAA) begin errors++; $display("FAIL rq_retry_resp: got resp %b rdata %h expected 01 000000005555aaaa", m_resp, m_rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write();
    test_miss();
    test_round_robin();
    test_timeout();
    test_reset_in_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
